// File: rtl/code_entry.sv
// code_entry: keypad-side code assembler for the digital lock.
// Collects four BCD digit keystrokes into a 16-bit code word. When Enter
// is pressed on a full code, it presents that word with a one-cycle
// o_code_valid strobe. Clear, premature Enter, over-entry, invalid keys
// and inactivity timeout are all handled here, so the comparator only
// ever sees complete, stable codes.
//
// Ports:
//   i_clk           system clock, rising edge
//   i_rst           synchronous active-high reset
//   i_key_valid     key event presented this cycle
//   i_key_value     0-9 digit, A clear, B enter, C-F invalid
//   o_ready         a key is accepted on an edge where i_key_valid && o_ready
//   o_entered_code  assembled code, first digit in [15:12]
//   o_digit_count   digits currently held (0-4)
//   o_code_valid    one-cycle strobe, o_entered_code complete and stable
//   o_entry_error   one-cycle strobe on a rejected key
//   o_timeout       one-cycle strobe when a partial entry is discarded
//
// state   | meaning
// --------+-------------------------------------------
// IDLE    | no digits held
// COLLECT | 1-3 digits held, inactivity counter running
// FULL    | 4 digits held, waiting for Enter
// PRESENT | code_valid cycle, keys refused
module code_entry #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_key_valid,
  input  logic [3:0]  i_key_value,
  output logic        o_ready,
  output logic [15:0] o_entered_code,
  output logic [2:0]  o_digit_count,
  output logic        o_code_valid,
  output logic        o_entry_error,
  output logic        o_timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The discard fires on the edge where the counter would step onto
  // TIMEOUT_CYCLES. The counter therefore only ever needs to hold up to
  // TIMEOUT_CYCLES-1.
  localparam logic [CW-1:0] LP_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FULL    = 2'd2,
    S_PRESENT = 2'd3
  } state_t;

  state_t        r_state;
  logic [15:0]   r_code;
  logic [2:0]    r_count;
  logic [CW-1:0] r_cnt;
  logic          r_ready;
  logic          r_valid;
  logic          r_err;
  logic          r_to;

  state_t        w_state_nxt;
  logic [15:0]   w_code_nxt;
  logic [2:0]    w_count_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_ready_nxt;
  logic          w_valid_nxt;
  logic          w_err_nxt;
  logic          w_to_nxt;
  logic          w_accept;
  logic          w_running;
  logic          w_expire;

  assign w_accept  = i_key_valid && r_ready;
  assign w_running = (r_state == S_COLLECT) || (r_state == S_FULL);
  assign w_expire  = (TIMEOUT_CYCLES != 0) && w_running && (r_cnt == LP_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_count <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_count <= w_count_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      r_to    <= w_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_count_nxt = r_count;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = 1'b1;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_to_nxt    = 1'b0;

    if (r_state == S_PRESENT) begin
      w_state_nxt = S_IDLE;
      w_code_nxt  = '0;
      w_count_nxt = '0;
      w_cnt_nxt   = '0;
    end else if (w_accept) begin
      // An accepted key always restarts the inactivity window. It also
      // beats a timeout expiring on the same edge.
      w_cnt_nxt = '0;
      if (i_key_value <= 4'd9) begin
        if (r_count < 3'd4) begin
          w_code_nxt  = {r_code[11:0], i_key_value};
          w_count_nxt = r_count + 3'd1;
          w_state_nxt = (r_count == 3'd3) ? S_FULL : S_COLLECT;
        end else begin
          w_err_nxt = 1'b1;
        end
      end else if (i_key_value == KEY_CLEAR) begin
        w_code_nxt  = '0;
        w_count_nxt = '0;
        w_state_nxt = S_IDLE;
      end else if (i_key_value == KEY_ENTER) begin
        if (r_state == S_FULL) begin
          w_state_nxt = S_PRESENT;
          w_valid_nxt = 1'b1;
          w_ready_nxt = 1'b0;
        end else begin
          w_err_nxt   = 1'b1;
          w_code_nxt  = '0;
          w_count_nxt = '0;
          w_state_nxt = S_IDLE;
        end
      end else begin
        w_err_nxt = 1'b1;
      end
    end else if (w_expire) begin
      w_code_nxt  = '0;
      w_count_nxt = '0;
      w_cnt_nxt   = '0;
      w_state_nxt = S_IDLE;
      w_to_nxt    = 1'b1;
    end else if (w_running) begin
      if (r_cnt != {CW{1'b1}}) w_cnt_nxt = r_cnt + CW'(1);
    end else begin
      w_cnt_nxt = '0;
    end
  end

  assign o_ready        = r_ready;
  assign o_entered_code = r_code;
  assign o_digit_count  = r_count;
  assign o_code_valid   = r_valid;
  assign o_entry_error  = r_err;
  assign o_timeout      = r_to;

endmodule

// File: doc/code_entry.md
# code_entry

Keypad-side code assembler for the digital lock. Collects four BCD digit keystrokes into the 16-bit `entered_code` word consumed by `comparator`, then presents the word with a one-cycle `code_valid` strobe when the user presses Enter. Handles clear, premature Enter, over-entry, invalid keys and inactivity timeout, so the comparator only ever sees complete, stable codes.

## Interface
- `TIMEOUT_CYCLES`, default 1000: number of consecutive cycles with no accepted key, while a partial code is held, before the entry is discarded. A value of 0 disables the timeout.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  a key event is presented this cycle.
- `key_value`  in  4  key code: 0x0–0x9 digit, 0xA Clear, 0xB Enter, 0xC–0xF invalid.
- `ready`  out  1  block accepts a key this cycle; a key is accepted on an edge where `key_valid && ready`.
- `entered_code`  out  16  assembled code, first digit in [15:12]; keys 1,2,3,4 give 16'h1234.
- `digit_count`  out  3  digits currently held, 0–4.
- `code_valid`  out  1  one-cycle strobe; `entered_code` is complete and stable while high.
- `entry_error`  out  1  one-cycle strobe on a rejected key.
- `timeout`  out  1  one-cycle strobe when a partial entry is discarded by inactivity.

## Operation
- All outputs are registered. Reset values: `entered_code`=0, `digit_count`=0, `code_valid`=0, `entry_error`=0, `timeout`=0, `ready`=1. The state is IDLE and the inactivity counter is 0.
- States:
  - IDLE: count 0.
  - COLLECT: count 1–3.
  - FULL: count 4.
  - PRESENT: `code_valid`=1, `ready`=0.
- Accepted digit with count<4:
  - `entered_code` <= {entered_code[11:0], key_value}; count+1.
  - IDLE→COLLECT, or COLLECT→FULL on the 4th digit.
- Accepted digit in FULL: ignored; code and count unchanged; `entry_error` pulses.
- Clear (0xA), any state except PRESENT: `entered_code`=0, count=0, → IDLE. No error is raised, including when already IDLE.
- Enter (0xB) in FULL: → PRESENT. `code_valid` is 1 for exactly one cycle and `entered_code` is held.
- Enter in IDLE or COLLECT: `entry_error` pulses; `entered_code`=0; count=0; → IDLE.
- Invalid key (0xC–0xF): `entry_error` pulses; code and count unchanged.
- Leaving PRESENT: unconditionally → IDLE on the next edge, with `entered_code`=0 and count=0. Keys are not accepted in PRESENT (`ready`=0); the source must hold `key_valid` until `ready` returns.
- Inactivity counter:
  - Reset to 0 by any accepted key.
  - Increments each cycle in COLLECT or FULL.
  - Held at 0 in IDLE and PRESENT.
  - Saturating width is clog2(TIMEOUT_CYCLES+1).
- When the counter reaches TIMEOUT_CYCLES: `entered_code`=0, count=0, → IDLE, and `timeout` pulses once.
- Simultaneous events:
  - An accepted key on the same edge as timeout expiry: the key wins. The key is processed normally and `timeout` does not pulse.
  - `rst` overrides everything, including mid-PRESENT; `code_valid` drops on the reset edge.

## Timing
- A key accepted at edge N is reflected in `entered_code`, `digit_count`, and the error/valid strobes after edge N (visible in cycle N+1).
- Enter→`code_valid` latency: 1 cycle. `code_valid` width: exactly 1 cycle. `ready` is low for that same cycle only.
- The comparator is combinational, so `match` is valid during the `code_valid` cycle. Downstream samples `match` only when `code_valid`=1.
- Back-to-back keys on consecutive cycles are accepted at full rate outside PRESENT. Minimum Enter-to-next-digit spacing is 2 cycles.
- Timeout: the last accepted digit at edge N, with no further keys, gives the discard at edge N+TIMEOUT_CYCLES. `timeout` is high in the following cycle.
- `entry_error` and `timeout` never both assert in the same cycle. `code_valid` never coincides with either.

## Test plan
- Reset, then keys 1,2,3,4,Enter on consecutive cycles → `digit_count` 1,2,3,4. `entered_code`=16'h1234 with `code_valid`=1 for one cycle and `ready`=0. Next cycle: `entered_code`=0, `digit_count`=0, `ready`=1.
- Keys 2,4,Enter → `entry_error` one-cycle pulse, `entered_code`=0, no `code_valid`. Then keys 0,0,0,7,Enter → `code_valid` with 16'h0007.
- Keys 4,5,8,7,9 → the 5th digit raises `entry_error`, `entered_code` stays 16'h4587, `digit_count`=4. Then Clear → `entered_code`=0, `digit_count`=0, no error.
- Key 0xE mid-entry after 9,5 → `entry_error`, code stays 16'h0095. Key 0xF in IDLE → `entry_error`, code stays 0.
- TIMEOUT_CYCLES=8: key 1, then idle → `timeout` pulses exactly 8 cycles after acceptance and `entered_code` returns to 0. A second run presenting key 2 on the expiry cycle → no `timeout`, code=16'h0012.
- Assert `rst` during the PRESENT cycle of 16'h2458 → all outputs return to their reset values on that edge; a fresh 1,5,7,6,Enter then gives `code_valid` with 16'h1576.
